// File: rtl/vec_mul_reduce_max.sv
// Pipelined element-wise multiply followed by a registered binary max-reduction tree.
// Define VMULMAX_SIGNED_EN to treat elements, products and the max comparison as two's-complement.
module vec_mul_reduce_max #(
  parameter int VECTOR_SIZE = 16,
  parameter int INT_SIZE    = 16
) (
  input  logic                            clock,
  input  logic                            resetn,
  input  logic [VECTOR_SIZE*INT_SIZE-1:0] a,
  input  logic [VECTOR_SIZE*INT_SIZE-1:0] x,
  output logic [INT_SIZE-1:0]             y
);

  localparam int LEVELS = $clog2(VECTOR_SIZE);

  typedef logic [INT_SIZE-1:0] elem_t;

  // Element count held by tree level `level` (level 0 is the product register).
  function automatic int count_at(int level);
    int n;
    n = VECTOR_SIZE;
    for (int k = 0; k < level; k++) n = (n + 1) / 2;
    return n;
  endfunction

  function automatic elem_t max_of(elem_t lhs, elem_t rhs);
`ifdef VMULMAX_SIGNED_EN
    return ($signed(rhs) > $signed(lhs)) ? rhs : lhs;
`else
    return (rhs > lhs) ? rhs : lhs;
`endif
  endfunction

  for (genvar l = 0; l <= LEVELS; l++) begin : g_level
    localparam int CNT = count_at(l);

    elem_t e [CNT];

    if (l == 0) begin : g_mul
      // The low INT_SIZE bits of a product are identical for signed and unsigned
      // operands, so only the comparison differs between the two arithmetic modes.
      always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
          // NOTE: every pipeline array entry is reset, so flushed data can never resurface.
          for (int i = 0; i < CNT; i++) e[i] <= '0;
        end else begin
          // NOTE: non-blocking assignments keep each level reading last cycle's values.
          for (int i = 0; i < CNT; i++)
            e[i] <= a[i*INT_SIZE +: INT_SIZE] * x[i*INT_SIZE +: INT_SIZE];
        end
      end
    end else begin : g_max
      localparam int PREV  = count_at(l - 1);
      localparam int PAIRS = PREV / 2;

      always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
          for (int i = 0; i < PAIRS; i++) e[i] <= '0;
        end else begin
          for (int i = 0; i < PAIRS; i++)
            e[i] <= max_of(g_level[l-1].e[2*i], g_level[l-1].e[2*i+1]);
        end
      end

      // An odd leftover element is delayed one stage so every path has equal latency.
      if (PREV % 2 == 1) begin : g_pass
        always_ff @(posedge clock or negedge resetn) begin
          if (!resetn) e[CNT-1] <= '0;
          else         e[CNT-1] <= g_level[l-1].e[PREV-1];
        end
      end
    end
  end

  assign y = g_level[LEVELS].e[0];

endmodule

// File: tb/tb_vec_mul_reduce_max.sv
// Scoreboard bench: four instances (N = 1, 2, 3, 16; INT_SIZE = 16) share one stimulus bus,
// a linear-scan reference model queues expected results, and a monitor compares them.
module tb_vec_mul_reduce_max;

  localparam int W      = 16;
  localparam int NDUT   = 4;
  localparam int NS [NDUT] = '{1, 2, 3, 16};

  typedef struct {
    logic [W-1:0] val;
    int           ready;
  } exp_t;

  logic         clock = 1'b0;
  logic         resetn = 1'b0;
  logic [255:0] a_bus = '0;
  logic [255:0] x_bus = '0;
  logic [W-1:0] y_d [NDUT];

  exp_t sb [NDUT][$];
  int   edge_count = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clock = ~clock;
  always @(posedge clock) edge_count <= edge_count + 1;

  vec_mul_reduce_max #(.VECTOR_SIZE(1),  .INT_SIZE(W)) dut_n1 (
    .clock(clock), .resetn(resetn), .a(a_bus[15:0]),  .x(x_bus[15:0]),  .y(y_d[0]));
  vec_mul_reduce_max #(.VECTOR_SIZE(2),  .INT_SIZE(W)) dut_n2 (
    .clock(clock), .resetn(resetn), .a(a_bus[31:0]),  .x(x_bus[31:0]),  .y(y_d[1]));
  vec_mul_reduce_max #(.VECTOR_SIZE(3),  .INT_SIZE(W)) dut_n3 (
    .clock(clock), .resetn(resetn), .a(a_bus[47:0]),  .x(x_bus[47:0]),  .y(y_d[2]));
  vec_mul_reduce_max #(.VECTOR_SIZE(16), .INT_SIZE(W)) dut_n16 (
    .clock(clock), .resetn(resetn), .a(a_bus),        .x(x_bus),        .y(y_d[3]));

  task automatic check(string name, logic [W-1:0] act, logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_count);
    end
  endtask

  function automatic bit greater(logic [W-1:0] l, logic [W-1:0] r);
`ifdef VMULMAX_SIGNED_EN
    return $signed(l) > $signed(r);
`else
    return l > r;
`endif
  endfunction

  // Reference: full-width products truncated to W bits, then a plain linear scan for the max.
  function automatic logic [W-1:0] ref_max(logic [255:0] av, logic [255:0] xv, int n);
    logic [31:0]  full;
    logic [W-1:0] p, best;
    best = '0;
    for (int i = 0; i < n; i++) begin
      full = av[i*W +: W] * xv[i*W +: W];
      p    = full[W-1:0];
      if (i == 0 || greater(p, best)) best = p;
    end
    return best;
  endfunction

  // Drive at the current (negedge) time; the next rising edge samples the inputs.
  task automatic drive_now(logic [255:0] av, logic [255:0] xv);
    exp_t e;
    a_bus = av;
    x_bus = xv;
    for (int d = 0; d < NDUT; d++) begin
      e.val   = ref_max(av, xv, NS[d]);
      e.ready = edge_count + 1 + $clog2(NS[d]);
      sb[d].push_back(e);
    end
  endtask

  task automatic apply(logic [255:0] av, logic [255:0] xv);
    @(negedge clock);
    drive_now(av, xv);
  endtask

  // Release reset; tree levels still hold reset zeros for the first LEVELS edges.
  task automatic release_reset();
    exp_t e;
    @(negedge clock);
    resetn = 1'b1;
    for (int d = 0; d < NDUT; d++)
      for (int k = 1; k <= $clog2(NS[d]); k++) begin
        e.val   = '0;
        e.ready = edge_count + k;
        sb[d].push_back(e);
      end
    drive_now('0, '0);
  endtask

  task automatic random_vec(output logic [255:0] v);
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    if ($urandom_range(3) == 0) v = v & {16{16'h000f}};
  endtask

  always @(negedge clock) begin : monitor
    exp_t e;
    if (resetn) begin
      for (int d = 0; d < NDUT; d++)
        while (sb[d].size() != 0 && sb[d][0].ready <= edge_count) begin
          e = sb[d].pop_front();
          check($sformatf("y_n%0d", NS[d]), y_d[d], e.val);
        end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [255:0] va, vx;
    int pending;

    repeat (3) @(posedge clock);
    #1;
    for (int d = 0; d < NDUT; d++) check($sformatf("reset_y_n%0d", NS[d]), y_d[d], '0);
    release_reset();

    // Basic: a={4,1}, x={2,4} -> products {8,4}, held for a few cycles.
    va = '0; vx = '0;
    va[15:0] = 16'd1; va[31:16] = 16'd4;
    vx[15:0] = 16'd4; vx[31:16] = 16'd2;
    repeat (3) apply(va, vx);

    // Truncation: 300*300 mod 65536 = 24464.
    va = '0; vx = '0;
    va[15:0] = 16'd300; vx[15:0] = 16'd300;
    va[31:16] = 16'd1;  vx[31:16] = 16'd1;
    apply(va, vx);

    // Tie (6,6), then all zero.
    va = '0; vx = '0;
    va[15:0] = 16'd2; va[31:16] = 16'd3;
    vx[15:0] = 16'd3; vx[31:16] = 16'd2;
    apply(va, vx);
    apply('0, '0);

    // Streaming: a[i]=i, x[i]=k -> 15k for the 16-wide instance.
    for (int k = 1; k <= 4; k++) begin
      va = '0; vx = '0;
      for (int i = 0; i < 16; i++) begin
        va[i*W +: W] = W'(i);
        vx[i*W +: W] = W'(k);
      end
      apply(va, vx);
    end

    // Odd count: {5,9,2}*1 -> 9.
    va = '0; vx = '0;
    va[15:0] = 16'd5; va[31:16] = 16'd9; va[47:32] = 16'd2;
    vx[15:0] = 16'd1; vx[31:16] = 16'd1; vx[47:32] = 16'd1;
    apply(va, vx);

`ifdef VMULMAX_SIGNED_EN
    // a={-3,2}, x={1,1} -> 2; a={-3,-2}, x={1,1} -> -2.
    va = '0; vx = '0;
    va[15:0] = 16'd2; va[31:16] = 16'hfffd;
    vx[15:0] = 16'd1; vx[31:16] = 16'd1;
    apply(va, vx);
    va[15:0] = 16'hfffe;
    apply(va, vx);
`endif

    for (int n = 0; n < 200; n++) begin
      random_vec(va);
      random_vec(vx);
      apply(va, vx);
    end

    // Mid-stream reset between edges with data in flight.
    @(negedge clock);
    #2 resetn = 1'b0;
    #1;
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("midreset_y_n%0d", NS[d]), y_d[d], '0);
      sb[d].delete();
    end
    repeat (2) @(posedge clock);
    #1;
    for (int d = 0; d < NDUT; d++) check($sformatf("held_reset_y_n%0d", NS[d]), y_d[d], '0);
    release_reset();

    for (int n = 0; n < 60; n++) begin
      random_vec(va);
      random_vec(vx);
      apply(va, vx);
    end

    pending = 1;
    for (int c = 0; c < 30 && pending != 0; c++) begin
      @(negedge clock);
      #1;
      pending = 0;
      for (int d = 0; d < NDUT; d++) pending += sb[d].size();
    end
    check("drain_pending", W'(pending), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
